// File: rtl/lmcnt_multi.sv
// lmcnt_multi: local-memory controller streaming two operand vectors from
// selectable local memories to the NPU and writing NPU results back into a
// selectable destination memory. One job at a time; configuration is latched
// when a job starts.
module lmcnt_multi #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 10,
  parameter int unsigned NMEM = 4,
  parameter int unsigned SW   = 2
) (
  input  logic                 CLK,
  input  logic                 RESET_X,
  input  logic                 SOFT_RESET,
  input  logic                 START,
  input  logic [AW-1:0]        LEN,
  input  logic [SW-1:0]        A_SEL,
  input  logic [SW-1:0]        B_SEL,
  input  logic [SW-1:0]        C_SEL,
  input  logic [AW-1:0]        A_BASE,
  input  logic [AW-1:0]        B_BASE,
  input  logic [AW-1:0]        C_BASE,
  output logic                 BUSY,
  output logic                 FINISH,
  output logic [NMEM*AW-1:0]   M_RADR,
  input  logic [NMEM*DW-1:0]   M_RDATA,
  output logic [NMEM-1:0]      M_WR,
  output logic [AW-1:0]        M_WADR,
  output logic [DW-1:0]        M_WDATA,
  output logic                 NPU_EN,
  output logic [DW-1:0]        A_RDATA,
  output logic [DW-1:0]        B_RDATA,
  input  logic                 LM_EN,
  input  logic [DW-1:0]        C_WDATA
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0] CNT_ONE = 1;

  state_t        state_q, state_d;
  logic [AW:0]   rcnt_q, rcnt_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic          finish_q, finish_d;

  // latched job configuration
  logic [AW:0]   len_q;
  logic [SW-1:0] asel_q, bsel_q, csel_q;
  logic [AW-1:0] abase_q, bbase_q, cbase_q;

  // read pipeline
  logic          rvld_q;
  logic          npu_en_q;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;

  logic          rst;
  logic          busy;
  logic          start_ok;
  logic          issue;
  logic          wr_ok;
  logic [AW-1:0] a_addr, b_addr;

  // Reset merge and per-cycle qualifiers for start, read issue and result acceptance.
  always_comb begin
    rst      = ~RESET_X | SOFT_RESET;
    busy     = (state_q != S_IDLE);
    start_ok = (state_q == S_IDLE) & START;
    issue    = (state_q == S_RUN);
    wr_ok    = busy & LM_EN & (wcnt_q < len_q);
  end

  // Capture the job configuration on an accepted start; LEN=0 becomes 2^AW.
  always_ff @(posedge CLK) begin
    if (rst) begin
      len_q   <= '0;
      asel_q  <= '0;
      bsel_q  <= '0;
      csel_q  <= '0;
      abase_q <= '0;
      bbase_q <= '0;
      cbase_q <= '0;
    end else if (start_ok) begin
      len_q   <= (LEN == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, LEN};
      asel_q  <= A_SEL;
      bsel_q  <= B_SEL;
      csel_q  <= C_SEL;
      abase_q <= A_BASE;
      bbase_q <= B_BASE;
      cbase_q <= C_BASE;
    end
  end

  // Job state, read/write counters and the registered completion pulse.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rcnt_q   <= '0;
      wcnt_q   <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      wcnt_q   <= wcnt_d;
      finish_q <= finish_d;
    end
  end

  // Next-state logic: issue LEN reads in RUN, then wait in DRAIN for LEN results.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    finish_d = 1'b0;
    wcnt_d   = wr_ok ? (wcnt_q + CNT_ONE) : wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_RUN;
          rcnt_d  = '0;
          wcnt_d  = '0;
        end
      end
      S_RUN: begin
        rcnt_d = rcnt_q + CNT_ONE;
        if (rcnt_q == (len_q - CNT_ONE)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wcnt_q == len_q) begin
          state_d  = S_IDLE;
          finish_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Per-memory read addresses; A is assigned last so it wins a shared select.
  always_comb begin
    a_addr = abase_q + rcnt_q[AW-1:0];
    b_addr = bbase_q + rcnt_q[AW-1:0];
    M_RADR = '0;
    if (issue) begin
      for (int unsigned i = 0; i < NMEM; i++) begin
        if (bsel_q == SW'(i)) begin
          M_RADR[i*AW +: AW] = b_addr;
        end
        if (asel_q == SW'(i)) begin
          M_RADR[i*AW +: AW] = a_addr;
        end
      end
    end
  end

  // Operand capture from the selected memories; out-of-range selects read as zero.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (rvld_q) begin
      a_d = '0;
      b_d = '0;
      for (int unsigned i = 0; i < NMEM; i++) begin
        if (asel_q == SW'(i)) begin
          a_d = M_RDATA[i*DW +: DW];
        end
        if (bsel_q == SW'(i)) begin
          b_d = M_RDATA[i*DW +: DW];
        end
      end
    end
  end

  // Two-stage read pipeline: address cycle, then data capture with NPU strobe.
  always_ff @(posedge CLK) begin
    if (rst) begin
      rvld_q   <= 1'b0;
      npu_en_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      rvld_q   <= issue;
      npu_en_q <= rvld_q;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  // Result write-back; memory 0 and out-of-range selects never get a write strobe.
  always_comb begin
    M_WR = '0;
    for (int unsigned i = 1; i < NMEM; i++) begin
      if (wr_ok && (csel_q == SW'(i))) begin
        M_WR[i] = 1'b1;
      end
    end
    M_WADR  = cbase_q + wcnt_q[AW-1:0];
    M_WDATA = C_WDATA;
  end

  // Status and operand outputs.
  always_comb begin
    BUSY    = busy;
    FINISH  = finish_q;
    NPU_EN  = npu_en_q;
    A_RDATA = a_q;
    B_RDATA = b_q;
  end

endmodule

// File: tb/tb_lmcnt_multi.sv
// Directed testbench for lmcnt_multi: memory and NPU models plus event logs
// checked against hand-derived expectations.
module tb_lmcnt_multi;

  localparam int DW   = 8;
  localparam int AW   = 10;
  localparam int NMEM = 4;
  localparam int SW   = 2;

  logic                 CLK = 1'b0;
  logic                 RESET_X;
  logic                 SOFT_RESET;
  logic                 START;
  logic [AW-1:0]        LEN;
  logic [SW-1:0]        A_SEL, B_SEL, C_SEL;
  logic [AW-1:0]        A_BASE, B_BASE, C_BASE;
  logic                 BUSY, FINISH;
  logic [NMEM*AW-1:0]   M_RADR;
  logic [NMEM*DW-1:0]   M_RDATA;
  logic [NMEM-1:0]      M_WR;
  logic [AW-1:0]        M_WADR;
  logic [DW-1:0]        M_WDATA;
  logic                 NPU_EN;
  logic [DW-1:0]        A_RDATA, B_RDATA;
  logic                 LM_EN;
  logic [DW-1:0]        C_WDATA;

  lmcnt_multi #(.DW(DW), .AW(AW), .NMEM(NMEM), .SW(SW)) dut (
    .CLK(CLK), .RESET_X(RESET_X), .SOFT_RESET(SOFT_RESET), .START(START),
    .LEN(LEN), .A_SEL(A_SEL), .B_SEL(B_SEL), .C_SEL(C_SEL),
    .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE),
    .BUSY(BUSY), .FINISH(FINISH), .M_RADR(M_RADR), .M_RDATA(M_RDATA),
    .M_WR(M_WR), .M_WADR(M_WADR), .M_WDATA(M_WDATA), .NPU_EN(NPU_EN),
    .A_RDATA(A_RDATA), .B_RDATA(B_RDATA), .LM_EN(LM_EN), .C_WDATA(C_WDATA)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory contents as a function of (memory, address); high address bits
  // alter the data so wrapped and unwrapped addresses are distinguishable.
  function automatic logic [7:0] memf(input int m, input int a);
    logic [9:0] ad;
    ad = a[9:0];
    case (m)
      0:       return ad[7:0] ^ {ad[9:8], ad[9:8], ad[9:8], ad[9:8]};
      1:       return ad[7:0] ^ {6'b0, ad[9:8]};
      2:       return (ad[7:0] + 8'h70) ^ {ad[9:8], 6'b0};
      default: return ad[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Read model: data appears one cycle after the address.
  always @(posedge CLK) begin
    for (int i = 0; i < NMEM; i++)
      M_RDATA[i*DW +: DW] <= memf(i, int'(M_RADR[i*AW +: AW]));
  end

  // NPU model: result = A+B, echoed three cycles after NPU_EN.
  logic [2:0] d_en = '0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic       lm_extra;
  always @(posedge CLK) begin
    d_en <= {d_en[1:0], NPU_EN};
    d0   <= A_RDATA + B_RDATA;
    d1   <= d0;
    d2   <= d1;
  end
  assign LM_EN   = d_en[2] | lm_extra;
  assign C_WDATA = d2;

  // Event logs, cleared on request from the stimulus process.
  logic [7:0] a_log[$], b_log[$];
  int n_cyc[$], w_adr[$], w_dat[$], w_msk[$];
  int fin_cnt, fin_cyc, wr0_cnt, ab_diff, last_lm;
  int clr_gen = 0, seen_gen = 0;

  always @(negedge CLK) begin
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      a_log.delete(); b_log.delete(); n_cyc.delete();
      w_adr.delete(); w_dat.delete(); w_msk.delete();
      fin_cnt = 0; fin_cyc = 0; wr0_cnt = 0; ab_diff = 0; last_lm = 0;
    end
    if (NPU_EN) begin
      a_log.push_back(A_RDATA);
      b_log.push_back(B_RDATA);
      n_cyc.push_back(cyc);
      if (A_RDATA !== B_RDATA) ab_diff++;
    end
    if (M_WR != '0) begin
      w_adr.push_back(int'(M_WADR));
      w_dat.push_back(int'(M_WDATA));
      w_msk.push_back(int'(M_WR));
    end
    if (M_WR[0]) wr0_cnt++;
    if (LM_EN && BUSY) last_lm = cyc;
    if (FINISH) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int start_cyc;
  logic [NMEM*AW-1:0] radr_first;

  task automatic start_job(input int len, input int asel, input int bsel, input int csel,
                           input int abase, input int bbase, input int cbase);
    @(posedge CLK); #1;
    clr_gen++;
    LEN = len[AW-1:0];
    A_SEL = asel[SW-1:0]; B_SEL = bsel[SW-1:0]; C_SEL = csel[SW-1:0];
    A_BASE = abase[AW-1:0]; B_BASE = bbase[AW-1:0]; C_BASE = cbase[AW-1:0];
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    // the running job must not see these
    LEN = ~LEN; A_SEL = ~A_SEL; B_SEL = ~B_SEL; C_SEL = ~C_SEL;
    A_BASE = ~A_BASE; B_BASE = ~B_BASE; C_BASE = ~C_BASE;
    @(negedge CLK); #1;
    start_cyc  = cyc;
    radr_first = M_RADR;
    chk("start_busy", BUSY, 1);
  endtask

  task automatic wait_done(input string t, input int budget);
    int n = 0;
    while (fin_cnt == 0 && n < budget) begin
      @(negedge CLK); #1;
      n++;
    end
    chk({t, "_done"}, (fin_cnt != 0), 1);
    repeat (4) begin
      @(negedge CLK); #1;
    end
  endtask

  task automatic check_job(input string t, input int len, input int asel, input int bsel,
                           input int csel, input int abase, input int bbase, input int cbase);
    int ae = 0, be = 0, we = 0, bb;
    logic [7:0] ea, eb, es;
    bb = (asel == bsel) ? abase : bbase;
    chk({t, "_npu_cnt"}, a_log.size(), len);
    if (n_cyc.size() > 0) begin
      chk({t, "_npu_lat"}, n_cyc[0] - start_cyc, 2);
      chk({t, "_npu_b2b"}, n_cyc[n_cyc.size()-1] - n_cyc[0], len - 1);
    end
    for (int k = 0; k < a_log.size(); k++) begin
      ea = memf(asel, (abase + k) % 1024);
      eb = memf(bsel, (bb + k) % 1024);
      es = ea + eb;
      if (a_log[k] !== ea) ae++;
      if (b_log[k] !== eb) be++;
      if (csel != 0 && k < w_adr.size()) begin
        if (w_adr[k] != (cbase + k) % 1024 || w_dat[k] != int'(es) || w_msk[k] != (1 << csel))
          we++;
      end
    end
    chk({t, "_a_err"}, ae, 0);
    chk({t, "_b_err"}, be, 0);
    if (csel != 0) begin
      chk({t, "_wr_cnt"}, w_adr.size(), len);
      chk({t, "_wr_err"}, we, 0);
    end else begin
      chk({t, "_wr_none"}, w_adr.size(), 0);
    end
    chk({t, "_wr0"}, wr0_cnt, 0);
    chk({t, "_fin_cnt"}, fin_cnt, 1);
    chk({t, "_fin_after"}, (fin_cyc > last_lm), 1);
    chk({t, "_busy_end"}, BUSY, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NMEM*AW-1:0] e;
    int ws, na;
    RESET_X = 1'b0; SOFT_RESET = 1'b0; START = 1'b0; lm_extra = 1'b0;
    LEN = '0; A_SEL = '0; B_SEL = '0; C_SEL = '0;
    A_BASE = '0; B_BASE = '0; C_BASE = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_finish", FINISH, 0);
    chk("rst_npu_en", NPU_EN, 0);
    chk("rst_a", A_RDATA, 0);
    chk("rst_b", B_RDATA, 0);
    chk("rst_wr", M_WR, 0);
    chk("rst_radr", M_RADR, 0);
    @(posedge CLK); #1;
    RESET_X = 1'b1;

    // basic job
    start_job(4, 1, 2, 3, 'h000, 'h010, 'h020);
    e = '0; e[2*AW +: AW] = 10'h010;
    chk("basic_radr", radr_first, e);
    wait_done("basic", 100);
    check_job("basic", 4, 1, 2, 3, 'h000, 'h010, 'h020);

    // address wrap on reads and writes
    start_job(4, 1, 2, 2, 'h3FF, 'h100, 'h3FE);
    e = '0; e[1*AW +: AW] = 10'h3FF; e[2*AW +: AW] = 10'h100;
    chk("wrap_radr", radr_first, e);
    wait_done("wrap", 100);
    check_job("wrap", 4, 1, 2, 2, 'h3FF, 'h100, 'h3FE);

    // START while busy, surplus LM_EN, restart in the FINISH cycle
    start_job(4, 1, 2, 3, 'h000, 'h010, 'h020);
    @(posedge CLK); #1; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    repeat (4) @(posedge CLK);
    #1; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    fork
      begin
        int n = 0;
        while (w_adr.size() < 4 && n < 60) begin
          @(negedge CLK); #1;
          n++;
        end
        @(posedge CLK); #1; lm_extra = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1; lm_extra = 1'b0;
      end
      begin
        int n = 0;
        while (!FINISH && n < 100) begin
          @(negedge CLK); #1;
          n++;
        end
        check_job("abuse", 4, 1, 2, 3, 'h000, 'h010, 'h020);
        LEN = 10'd2; A_SEL = 2'd3; B_SEL = 2'd1; C_SEL = 2'd2;
        A_BASE = 10'h040; B_BASE = 10'h050; C_BASE = 10'h060;
        START = 1'b1;
        clr_gen++;
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK); #1;
        start_cyc = cyc;
        chk("restart_busy", BUSY, 1);
      end
    join
    wait_done("restart", 100);
    check_job("restart", 2, 3, 1, 2, 'h040, 'h050, 'h060);

    // discard destination
    start_job(8, 1, 2, 0, 'h000, 'h010, 'h000);
    wait_done("discard", 100);
    check_job("discard", 8, 1, 2, 0, 'h000, 'h010, 'h000);

    // LEN=0 means 1024 elements; shared select on read-only memory 0
    start_job(1024, 0, 0, 1, 5, 77, 'h100);
    wait_done("len0", 1300);
    check_job("len0", 1024, 0, 0, 1, 5, 77, 'h100);
    chk("len0_ab_same", ab_diff, 0);

    // soft reset mid-job
    start_job(8, 1, 2, 3, 'h000, 'h010, 'h020);
    begin
      int n = 0;
      while (a_log.size() < 3 && n < 50) begin
        @(negedge CLK); #1;
        n++;
      end
    end
    @(posedge CLK); #1; SOFT_RESET = 1'b1;
    @(posedge CLK); #1; SOFT_RESET = 1'b0;
    @(negedge CLK); #1;
    chk("sr_npu_en", NPU_EN, 0);
    chk("sr_busy", BUSY, 0);
    chk("sr_a", A_RDATA, 0);
    chk("sr_b", B_RDATA, 0);
    ws = w_adr.size();
    na = a_log.size();
    repeat (15) begin
      @(negedge CLK); #1;
    end
    chk("sr_no_write", w_adr.size(), ws);
    chk("sr_no_npu", a_log.size(), na);
    chk("sr_no_finish", fin_cnt, 0);
    start_job(4, 1, 2, 3, 'h000, 'h010, 'h020);
    wait_done("post_sr", 100);
    check_job("post_sr", 4, 1, 2, 3, 'h000, 'h010, 'h020);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
